lap_ctrl: RTL

- Control FSM for the stopwatch lap-time memory and the running time counter.
- Debounces the three front-panel buttons and sequences the counter as IDLE/RUN/STOP.
- Issues write strobes and addresses that store lap times into the lap memory.
- Steps the read address while the user browses stored laps; also selects live vs. recalled time for the 7-seg display mux.

---
 rtl/lap_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lap_ctrl.sv
// Stopwatch lap-memory controller: debounces three buttons and sequences the
// counter and lap memory through IDLE / RUN / STOP / VIEW.
module lap_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int DB_CYCLES = 500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_ss,
  input  logic          btn_lap,
  input  logic          btn_view,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic          disp_sel,
  output logic [AW:0]   lap_count,
  output logic          full,
  output logic [1:0]    state
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES - 1);
  localparam logic [AW:0]   LAP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAP_ONE  = (AW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;
  localparam logic [1:0] S_VIEW = 2'b11;

  logic [2:0]    raw;
  logic [2:0]    level;
  logic [2:0]    flip;
  logic [2:0]    rise;
  logic [CW-1:0] db_cnt [3];
  logic          ev_ss, ev_lap, ev_view;

  logic [1:0]    state_n;
  logic          we_n, clr_n;
  logic [AW-1:0] waddr_n, raddr_n;
  logic [AW:0]   count_n;

  assign raw = {btn_view, btn_lap, btn_ss};

  // The event fires in the cycle before the accepted level flips, so the FSM
  // reacts on the same edge that the debounced level changes.
  always_comb begin
    flip = '0;
    for (int unsigned i = 0; i < 3; i++)
      flip[i] = (raw[i] != level[i]) && (db_cnt[i] == DB_MAX);
  end

  assign rise    = flip & raw;
  assign ev_ss   = rise[0];
  assign ev_lap  = rise[1] & ~rise[0];
  assign ev_view = rise[2] & ~rise[1] & ~rise[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (raw[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          db_cnt[i] <= '0;
          level[i]  <= raw[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign full = (lap_count == LAP_FULL);

  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    clr_n   = 1'b0;
    waddr_n = mem_waddr;
    raddr_n = mem_raddr;
    count_n = lap_count;
    case (state)
      S_IDLE: begin
        if (ev_ss) state_n = S_RUN;
      end
      S_RUN: begin
        if (ev_ss) begin
          state_n = S_STOP;
        end else if (ev_lap && !full) begin
          we_n    = 1'b1;
          waddr_n = lap_count[AW-1:0];
          count_n = lap_count + LAP_ONE;
        end
      end
      S_STOP: begin
        if (ev_ss) begin
          state_n = S_RUN;
        end else if (ev_lap) begin
          clr_n   = 1'b1;
          count_n = '0;
          raddr_n = '0;
          state_n = S_IDLE;
        end else if (ev_view && lap_count != '0) begin
          raddr_n = '0;
          state_n = S_VIEW;
        end
      end
      default: begin
        if (ev_lap) begin
          if ({1'b0, mem_raddr} == lap_count - LAP_ONE) raddr_n = '0;
          else                                           raddr_n = mem_raddr + AW'(1);
        end else if (ev_view) begin
          raddr_n = '0;
          state_n = S_STOP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_raddr <= '0;
      disp_sel  <= 1'b0;
      lap_count <= '0;
    end else begin
      state     <= state_n;
      cnt_en    <= (state_n == S_RUN);
      cnt_clr   <= clr_n;
      mem_we    <= we_n;
      mem_waddr <= waddr_n;
      mem_raddr <= raddr_n;
      disp_sel  <= (state_n == S_VIEW);
      lap_count <= count_n;
    end
  end

endmodule
